// File: rtl/ad9363_if_pkg.sv
// ---------------------------------------------------------------------------
// ad9363_if_pkg
// Shared definitions for the AD9363 CMOS framer/deframer.
//   rx_state_e          : receive alignment state (SEARCH / VERIFY / LOCKED)
//   words_per_frame()   : I/Q words carried in one frame for a channel count
//   expected_frame_bit(): level the frame line must have at word index k
// ---------------------------------------------------------------------------
package ad9363_if_pkg;

  typedef enum logic [1:0] {
    RX_SEARCH = 2'd0,
    RX_VERIFY = 2'd1,
    RX_LOCKED = 2'd2
  } rx_state_e;

  // Word order within a frame is I0,Q0,I1,Q1.
  function automatic int words_per_frame(input int num_ch);
    return 2 * num_ch;
  endfunction

  // The frame line is high for the first NUM_CH words and low for the rest,
  // so 1R1T toggles every word and 2R2T toggles every two words.
  function automatic logic expected_frame_bit(input int k, input int num_ch);
    return (k < num_ch);
  endfunction

endpackage

// File: rtl/ad9363_rx_align_fsm.sv
// ---------------------------------------------------------------------------
// ad9363_rx_align_fsm
// Receive frame alignment: frame-start edge detect, word counter, lock/verify
// state machine and link-health counters.
//
// Ports
//   clk         in   data clock, one captured word per cycle
//   rst         in   asynchronous active-high reset
//   frame_bit   in   captured frame bit for the current word
//   word_idx    out  slot index of the current word within the frame
//   word_wr     out  current word belongs to a tracked frame (write to buffer)
//   frame_emit  out  current word completes a good frame while LOCKED
//   rx_status   out  high while LOCKED
//   rx_err_cnt  out  saturating count of bad frames seen while LOCKED
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_SEARCH  | waiting for a 0->1 frame edge to mark word 0
// RX_VERIFY  | counting clean frames; any bad frame bit returns to SEARCH
// RX_LOCKED  | aligned; frames are emitted, bad frames counted
// ---------------------------------------------------------------------------
module ad9363_rx_align_fsm
  import ad9363_if_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 2,
  localparam int W          = words_per_frame(NUM_CH),
  localparam int CNT_W      = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_bit,
  output logic [CNT_W-1:0] word_idx,
  output logic             word_wr,
  output logic             frame_emit,
  output logic             rx_status,
  output logic [15:0]      rx_err_cnt
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  rx_state_e        state;
  logic             prev_frame;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_run;
  logic             frame_bad;

  logic             start;
  logic             mismatch;
  logic             last_word;
  logic             frame_bad_now;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    start         = frame_bit & ~prev_frame;
    // In SEARCH the only word we act on is a frame start, which is word 0.
    word_idx      = (state == RX_SEARCH) ? '0 : cnt;
    word_wr       = (state != RX_SEARCH) || start;
    mismatch      = (frame_bit != expected_frame_bit(32'(word_idx), NUM_CH));
    last_word     = (word_idx == CNT_W'(W - 1));
    frame_bad_now = frame_bad | mismatch;
    frame_emit    = (state == RX_LOCKED) && last_word && !frame_bad_now;
    cnt_next      = last_word ? '0 : word_idx + CNT_W'(1);
  end

  assign rx_status = (state == RX_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_SEARCH;
      // Reset high so a frame line held high through reset is not a start.
      prev_frame <= 1'b1;
      cnt        <= '0;
      good_cnt   <= '0;
      bad_run    <= '0;
      frame_bad  <= 1'b0;
      rx_err_cnt <= '0;
    end else begin
      prev_frame <= frame_bit;
      case (state)
        RX_SEARCH: begin
          if (start) begin
            state     <= RX_VERIFY;
            cnt       <= cnt_next;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
          end
        end
        RX_VERIFY: begin
          if (mismatch) begin
            state <= RX_SEARCH;
          end else begin
            cnt <= cnt_next;
            if (last_word) begin
              if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                state     <= RX_LOCKED;
                bad_run   <= '0;
                frame_bad <= 1'b0;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end
          end
        end
        RX_LOCKED: begin
          cnt <= cnt_next;
          if (last_word) begin
            frame_bad <= 1'b0;
            if (frame_bad_now) begin
              if (rx_err_cnt != 16'hFFFF) rx_err_cnt <= rx_err_cnt + 16'd1;
              if (bad_run == BW'(UNLOCK_ERRS - 1)) begin
                state   <= RX_SEARCH;
                bad_run <= '0;
              end else begin
                bad_run <= bad_run + BW'(1);
              end
            end else begin
              bad_run <= '0;
            end
          end else begin
            frame_bad <= frame_bad_now;
          end
        end
        default: state <= RX_SEARCH;
      endcase
    end
  end

endmodule

// File: rtl/ad9363_cmos_framer.sv
// ---------------------------------------------------------------------------
// ad9363_cmos_framer
// Word-level framer/deframer for the AD9363 CMOS data port (1R1T / 2R2T),
// between the IDDR/ODDR capture layer and user logic, all on data_clk.
//
// Ports
//   data_clk      in   single clock, one RX and one TX word per cycle
//   rst           in   asynchronous active-high reset
//   rx_frame_in   in   captured frame bit
//   rx_data_in    in   captured data word
//   adc_valid     out  one-cycle pulse, adc_data holds a full frame
//   adc_data      out  {Q(n-1),I(n-1),...,Q0,I0}, I0 in the LSBs
//   rx_status     out  high while aligned
//   rx_err_cnt    out  bad frames seen while aligned, saturating
//   dac_valid     in   user sample valid (only looked at in the ready slot)
//   dac_data      in   same packing as adc_data
//   dac_ready     out  high in the last word slot of the TX frame
//   tx_underflow  out  one-cycle pulse, a frame went out as zeros
//   tx_frame_out  out  framed TX frame bit
//   tx_data_out   out  framed TX word
// ---------------------------------------------------------------------------
module ad9363_cmos_framer
  import ad9363_if_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 1,
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 2,
  localparam int W          = words_per_frame(NUM_CH),
  localparam int FW         = W * DATA_W,
  localparam int CNT_W      = $clog2(W)
) (
  input  logic              data_clk,
  input  logic              rst,
  input  logic              rx_frame_in,
  input  logic [DATA_W-1:0] rx_data_in,
  output logic              adc_valid,
  output logic [FW-1:0]     adc_data,
  output logic              rx_status,
  output logic [15:0]       rx_err_cnt,
  input  logic              dac_valid,
  input  logic [FW-1:0]     dac_data,
  output logic              dac_ready,
  output logic              tx_underflow,
  output logic              tx_frame_out,
  output logic [DATA_W-1:0] tx_data_out
);

  // ---------------- receive ----------------
  logic [CNT_W-1:0] word_idx;
  logic             word_wr;
  logic             frame_emit;
  logic [FW-1:0]    frame_buf;
  logic [FW-1:0]    frame_next;

  ad9363_rx_align_fsm #(
    .NUM_CH      (NUM_CH),
    .LOCK_FRAMES (LOCK_FRAMES),
    .UNLOCK_ERRS (UNLOCK_ERRS)
  ) u_rx_align (
    .clk        (data_clk),
    .rst        (rst),
    .frame_bit  (rx_frame_in),
    .word_idx   (word_idx),
    .word_wr    (word_wr),
    .frame_emit (frame_emit),
    .rx_status  (rx_status),
    .rx_err_cnt (rx_err_cnt)
  );

  // The completed frame includes the word arriving this cycle, so adc_data
  // is taken from the merged view rather than the buffer register.
  always_comb begin
    frame_next = frame_buf;
    frame_next[int'(word_idx)*DATA_W +: DATA_W] = rx_data_in;
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      frame_buf <= '0;
      adc_data  <= '0;
      adc_valid <= 1'b0;
    end else begin
      if (word_wr) frame_buf <= frame_next;
      adc_valid <= frame_emit;
      if (frame_emit) adc_data <= frame_next;
    end
  end

  // ---------------- transmit ----------------
  // tx_cnt is the slot of the word currently on tx_data_out; the load for
  // the next frame happens on the edge leaving slot W-1.
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] tx_cnt_next;
  logic             tx_last;
  logic [FW-1:0]    tx_load;
  logic [FW-1:0]    tx_shift;

  always_comb begin
    tx_last     = (tx_cnt == CNT_W'(W - 1));
    tx_cnt_next = tx_last ? '0 : tx_cnt + CNT_W'(1);
    tx_load     = dac_valid ? dac_data : '0;
  end

  assign dac_ready = tx_last;

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      tx_cnt       <= CNT_W'(W - 1);
      tx_shift     <= '0;
      tx_data_out  <= '0;
      tx_frame_out <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      tx_cnt       <= tx_cnt_next;
      tx_frame_out <= expected_frame_bit(32'(tx_cnt_next), NUM_CH);
      tx_underflow <= tx_last && !dac_valid;
      if (tx_last) begin
        tx_data_out <= tx_load[DATA_W-1:0];
        tx_shift    <= tx_load >> DATA_W;
      end else begin
        tx_data_out <= tx_shift[DATA_W-1:0];
        tx_shift    <= tx_shift >> DATA_W;
      end
    end
  end

endmodule

// File: tb/tb_ad9363_cmos_framer.sv
module tb_ad9363_cmos_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 1R1T instance
  logic        f1 = 1'b0;
  logic [11:0] d1 = '0;
  logic        dv1 = 1'b0;
  logic [23:0] dd1 = '0;
  logic        av1, st1, dr1, uf1, tf1;
  logic [23:0] ad1;
  logic [15:0] ec1;
  logic [11:0] td1;

  // 2R2T instance
  logic        f2 = 1'b0;
  logic [11:0] d2 = '0;
  logic        dv2 = 1'b0;
  logic [47:0] dd2 = '0;
  logic        av2, st2, dr2, uf2, tf2;
  logic [47:0] ad2;
  logic [15:0] ec2;
  logic [11:0] td2;

  int total = 0;
  int bad   = 0;

  ad9363_cmos_framer #(.DATA_W(12), .NUM_CH(1), .LOCK_FRAMES(4), .UNLOCK_ERRS(2)) dut1 (
    .data_clk(clk), .rst(rst), .rx_frame_in(f1), .rx_data_in(d1),
    .adc_valid(av1), .adc_data(ad1), .rx_status(st1), .rx_err_cnt(ec1),
    .dac_valid(dv1), .dac_data(dd1), .dac_ready(dr1), .tx_underflow(uf1),
    .tx_frame_out(tf1), .tx_data_out(td1)
  );

  ad9363_cmos_framer #(.DATA_W(12), .NUM_CH(2), .LOCK_FRAMES(4), .UNLOCK_ERRS(2)) dut2 (
    .data_clk(clk), .rst(rst), .rx_frame_in(f2), .rx_data_in(d2),
    .adc_valid(av2), .adc_data(ad2), .rx_status(st2), .rx_err_cnt(ec2),
    .dac_valid(dv2), .dac_data(dd2), .dac_ready(dr2), .tx_underflow(uf2),
    .tx_frame_out(tf2), .tx_data_out(td2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx1_frame(input logic [11:0] i0, input logic [11:0] q0);
    f1 = 1'b1; d1 = i0; step();
    f1 = 1'b0; d1 = q0; step();
  endtask

  // bad_word < 0 sends a clean frame; otherwise that word's frame bit is inverted
  task automatic rx2_frame(input logic [11:0] i0, input logic [11:0] q0,
                           input logic [11:0] i1, input logic [11:0] q1, input int bad_word);
    logic [11:0] w [4];
    w = '{i0, q0, i1, q1};
    for (int k = 0; k < 4; k++) begin
      f2 = (k < 2) ^ (k == bad_word);
      d2 = w[k];
      step();
    end
  endtask

  task automatic wait_ready2();
    int n = 0;
    while (dr2 !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    total++;
    if (dr2 !== 1'b1) begin bad++; $display("FAIL ready2_timeout: dac_ready=%b want 1", dr2); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++; if ({av1, st1, dr1, uf1, tf1} !== 5'b00100) begin bad++; $display("FAIL rst1_flags: {valid,status,ready,uflow,frame}=%b want 00100", {av1, st1, dr1, uf1, tf1}); end
    total++; if (ad1 !== 24'h0 || ec1 !== 16'h0 || td1 !== 12'h0) begin bad++; $display("FAIL rst1_data: adc=%h err=%h tx=%h want 0", ad1, ec1, td1); end
    total++; if ({av2, st2, dr2, uf2, tf2} !== 5'b00100) begin bad++; $display("FAIL rst2_flags: {valid,status,ready,uflow,frame}=%b want 00100", {av2, st2, dr2, uf2, tf2}); end
    total++; if (ad2 !== 48'h0 || ec2 !== 16'h0 || td2 !== 12'h0) begin bad++; $display("FAIL rst2_data: adc=%h err=%h tx=%h want 0", ad2, ec2, td2); end
    rst = 1'b0;
    #1;
    total++; if (dr1 !== 1'b1 || dr2 !== 1'b1) begin bad++; $display("FAIL rst_release_ready: ready1=%b ready2=%b want 1", dr1, dr2); end
  endtask

  task automatic test_lock_1ch();
    f1 = 1'b0;
    repeat (3) step();
    for (int n = 1; n <= 4; n++) begin
      rx1_frame(12'h123, 12'h456);
      total++; if (st1 !== 1'(n == 4)) begin bad++; $display("FAIL lock1_status_f%0d: rx_status=%b want %b", n, st1, (n == 4)); end
      total++; if (av1 !== 1'b0) begin bad++; $display("FAIL lock1_novalid_f%0d: adc_valid=%b want 0", n, av1); end
    end
    f1 = 1'b1; d1 = 12'h123; step();
    total++; if (av1 !== 1'b0) begin bad++; $display("FAIL lock1_mid: adc_valid=%b want 0", av1); end
    f1 = 1'b0; d1 = 12'h456; step();
    total++; if (av1 !== 1'b1) begin bad++; $display("FAIL lock1_valid5: adc_valid=%b want 1", av1); end
    total++; if (ad1 !== 24'h456123) begin bad++; $display("FAIL lock1_data5: adc_data=%h want 456123", ad1); end
    f1 = 1'b1; d1 = 12'hABC; step();
    total++; if (av1 !== 1'b0 || ad1 !== 24'h456123) begin bad++; $display("FAIL lock1_pulse: adc_valid=%b adc_data=%h want 0 456123", av1, ad1); end
    f1 = 1'b0; d1 = 12'hDEF; step();
    total++; if (av1 !== 1'b1 || ad1 !== 24'hDEFABC) begin bad++; $display("FAIL lock1_data6: adc_valid=%b adc_data=%h want 1 defabc", av1, ad1); end
  endtask

  task automatic test_bad_frames_2ch();
    f2 = 1'b0;
    repeat (3) step();
    for (int n = 1; n <= 4; n++) begin
      rx2_frame(12'h001, 12'h002, 12'h003, 12'h004, -1);
      total++; if (st2 !== 1'(n == 4) || av2 !== 1'b0) begin bad++; $display("FAIL lock2_f%0d: status=%b valid=%b want %b 0", n, st2, av2, (n == 4)); end
    end
    rx2_frame(12'h111, 12'h222, 12'h333, 12'h444, -1);
    total++; if (av2 !== 1'b1 || ad2 !== 48'h444333222111) begin bad++; $display("FAIL lock2_emit: valid=%b data=%h want 1 444333222111", av2, ad2); end
    rx2_frame(12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 2);
    total++; if (ec2 !== 16'd1 || st2 !== 1'b1 || av2 !== 1'b0) begin bad++; $display("FAIL bad1: err=%0d status=%b valid=%b want 1 1 0", ec2, st2, av2); end
    total++; if (ad2 !== 48'h444333222111) begin bad++; $display("FAIL bad1_hold: adc_data=%h want 444333222111", ad2); end
    rx2_frame(12'h555, 12'h666, 12'h777, 12'h888, -1);
    total++; if (av2 !== 1'b1 || ad2 !== 48'h888777666555 || ec2 !== 16'd1) begin bad++; $display("FAIL good_between: valid=%b data=%h err=%0d want 1 888777666555 1", av2, ad2, ec2); end
    rx2_frame(12'h010, 12'h020, 12'h030, 12'h040, 2);
    total++; if (ec2 !== 16'd2 || st2 !== 1'b1) begin bad++; $display("FAIL bad2_run_reset: err=%0d status=%b want 2 1", ec2, st2); end
    rx2_frame(12'h050, 12'h060, 12'h070, 12'h080, 0);
    total++; if (ec2 !== 16'd3 || st2 !== 1'b0 || av2 !== 1'b0) begin bad++; $display("FAIL unlock: err=%0d status=%b valid=%b want 3 0 0", ec2, st2, av2); end
    f2 = 1'b0;
    repeat (4) step();
    total++; if (ec2 !== 16'd3 || st2 !== 1'b0) begin bad++; $display("FAIL err_hold: err=%0d status=%b want 3 0", ec2, st2); end
  endtask

  task automatic test_reset_mid();
    f2 = 1'b0; dv2 = 1'b0;
    wait_ready2();
    dv2 = 1'b1; dd2 = 48'h004003002001;
    rx2_frame(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, -1);
    f2 = 1'b1; d2 = 12'h0AA; step();
    total++; if (td2 !== 12'h001 || tf2 !== 1'b1 || st2 !== 1'b0 || ad2 !== 48'h888777666555) begin bad++; $display("FAIL pre_rst: tx=%h frame=%b status=%b adc=%h want 001 1 0 888777666555", td2, tf2, st2, ad2); end
    rst = 1'b1;
    #1;
    total++; if ({av2, st2, dr2, uf2, tf2} !== 5'b00100) begin bad++; $display("FAIL midrst_flags: {valid,status,ready,uflow,frame}=%b want 00100", {av2, st2, dr2, uf2, tf2}); end
    total++; if (ad2 !== 48'h0 || ec2 !== 16'h0 || td2 !== 12'h0) begin bad++; $display("FAIL midrst_data: adc=%h err=%h tx=%h want 0", ad2, ec2, td2); end
    step(); step();
    rst = 1'b0; dv2 = 1'b0; f2 = 1'b0;
    #1;
    total++; if (dr2 !== 1'b1 || td2 !== 12'h0 || tf2 !== 1'b0) begin bad++; $display("FAIL midrst_release: ready=%b tx=%h frame=%b want 1 000 0", dr2, td2, tf2); end
  endtask

  task automatic test_frame_high_reset();
    f2 = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    total++; if (st2 !== 1'b0) begin bad++; $display("FAIL high_hold: rx_status=%b want 0", st2); end
    f2 = 1'b0;
    step(); step();
    for (int n = 1; n <= 4; n++) begin
      rx2_frame(12'h101, 12'h202, 12'h303, 12'h404, -1);
      total++; if (st2 !== 1'(n == 4)) begin bad++; $display("FAIL high_lock_f%0d: rx_status=%b want %b", n, st2, (n == 4)); end
    end
  endtask

  task automatic test_tx();
    f2 = 1'b0; dv2 = 1'b0;
    wait_ready2();
    dv2 = 1'b1; dd2 = 48'h004003002001;
    step();
    total++; if (td2 !== 12'd1 || tf2 !== 1'b1 || dr2 !== 1'b0 || uf2 !== 1'b0) begin bad++; $display("FAIL tx_w0: data=%h frame=%b ready=%b uflow=%b want 001 1 0 0", td2, tf2, dr2, uf2); end
    dd2 = 48'hFFFEEEDDDCCC;
    for (int k = 1; k < 4; k++) begin
      step();
      total++; if (td2 !== 12'(k + 1) || tf2 !== 1'(k < 2)) begin bad++; $display("FAIL tx_w%0d: data=%h frame=%b want %0h %b", k, td2, tf2, k + 1, (k < 2)); end
    end
    total++; if (dr2 !== 1'b1) begin bad++; $display("FAIL tx_ready_last: dac_ready=%b want 1", dr2); end
    dv2 = 1'b0;
  endtask

  task automatic test_underflow();
    int pulses = 0;
    dv2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (uf2 === 1'b1) pulses++;
      total++; if (td2 !== 12'h0 || uf2 !== 1'(k == 0)) begin bad++; $display("FAIL uflow_w%0d: data=%h uflow=%b want 000 %b", k, td2, uf2, (k == 0)); end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL uflow_pulses: count=%0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wait_ready2();
    dv2 = 1'b1; dd2 = 48'h008007006005;
    step();
    dd2 = 48'h00C00B00A009;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      total++; if (td2 !== 12'(5 + k) || uf2 !== 1'b0) begin bad++; $display("FAIL b2b_w%0d: data=%h uflow=%b want %0h 0", k, td2, uf2, 5 + k); end
    end
    dv2 = 1'b0;
    while (dr1 !== 1'b1 && n < 4) begin step(); n++; end
    total++; if (dr1 !== 1'b1) begin bad++; $display("FAIL ready1_timeout: dac_ready=%b want 1", dr1); end
    dv1 = 1'b1; dd1 = 24'h0BB0AA;
    step();
    dv1 = 1'b0;
    total++; if (td1 !== 12'h0AA || tf1 !== 1'b1) begin bad++; $display("FAIL tx1_w0: data=%h frame=%b want 0aa 1", td1, tf1); end
    step();
    total++; if (td1 !== 12'h0BB || tf1 !== 1'b0) begin bad++; $display("FAIL tx1_w1: data=%h frame=%b want 0bb 0", td1, tf1); end
    step();
    total++; if (td1 !== 12'h0 || uf1 !== 1'b1) begin bad++; $display("FAIL tx1_uflow: data=%h uflow=%b want 000 1", td1, uf1); end
  endtask

  initial begin
    test_reset();
    test_lock_1ch();
    test_bad_frames_2ch();
    test_reset_mid();
    test_frame_high_reset();
    test_tx();
    test_underflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
